idecode32_rf: RTL



---
 rtl/minisys_pkg.sv | 17 +
 rtl/regfile32x32.sv | 41 ++++
 rtl/idecode32_rf.sv | 101 ++++++++++
 3 files changed

// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared Minisys opcode and register-index constants
package minisys_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile32x32.sv
// rtl/regfile32x32.sv - general register file, two read ports, debug port, one write port
module regfile32x32 #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  input  logic [AW-1:0]     i_dbg_addr,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int NREG = 1 << AW;

  logic [DATA_W-1:0] r_mem [NREG];

  // Storage: asynchronous clear has priority; writes to r0 are dropped so it never holds data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are combinational with no write bypass; r0 is hard-wired to zero
  always_comb begin
    o_rdata1   = (i_raddr1 == '0)   ? '0 : r_mem[i_raddr1];
    o_rdata2   = (i_raddr2 == '0)   ? '0 : r_mem[i_raddr2];
    o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
  end

endmodule

// File: rtl/idecode32_rf.sv
// rtl/idecode32_rf.sv - Minisys decode stage: register file, immediate extension, write-back
module idecode32_rf
  import minisys_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] opcplus4,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic              Jal,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              RegDst,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] Read_data_1,
  output logic [DATA_W-1:0] Read_data_2,
  output logic [DATA_W-1:0] Sign_extend,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_busy_o
);

  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [15:0]       w_imm;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              r_wr_busy;

  assign w_opcode = Instruction[31:26];
  assign w_rs     = Instruction[25:21];
  assign w_rt     = Instruction[20:16];
  assign w_rd     = Instruction[15:11];
  assign w_imm    = Instruction[15:0];
  assign w_we     = RegWrite | Jal;

  // Logical immediates and sltiu take a zero-extended operand; everything else sign-extends
  always_comb begin
    Sign_extend = {{(DATA_W-16){w_imm[15]}}, w_imm};
    case (w_opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: Sign_extend = {{(DATA_W-16){1'b0}}, w_imm};
      default: ;
    endcase
  end

  // Destination select: jal forces the link register, then RegDst picks rd over rt
  always_comb begin
    w_waddr = w_rt;
    if (Jal) begin
      w_waddr = REG_AW'(LINK_REG);
    end else if (RegDst) begin
      w_waddr = w_rd;
    end
  end

  // Write-data select: jal forces the return address, then MemtoReg picks memory over ALU
  always_comb begin
    w_wdata = ALU_result;
    if (Jal) begin
      w_wdata = opcplus4;
    end else if (MemtoReg) begin
      w_wdata = read_data;
    end
  end

  // Status flag: high for the cycle following any write that actually lands in a register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_busy <= 1'b0;
    end else begin
      r_wr_busy <= w_we && (w_waddr != REG_AW'(REG_ZERO));
    end
  end

  assign wr_busy_o = r_wr_busy;

  regfile32x32 #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_regfile (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_raddr1   (w_rs),
    .i_raddr2   (w_rt),
    .i_dbg_addr (dbg_addr),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .o_rdata1   (Read_data_1),
    .o_rdata2   (Read_data_2),
    .o_dbg_data (dbg_data)
  );

endmodule
